// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache, 8 lines x 4 bytes
module dcache_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE} state_t;

    state_t      state;
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tags [8];
    logic [31:0] data [8];
    logic        seen_busy;

    logic [2:0]  tag_in;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic        hit;
    logic        request;
    logic        complete;
    logic        fill;
    logic        store;
    logic [31:0] line;

    assign tag_in   = address[7:5];
    assign index    = address[4:2];
    assign offset   = address[1:0];
    assign hit      = valid[index] && (tags[index] == tag_in);
    assign request  = read || write;
    // Completion needs a busy phase first so a slow-to-react memory is never mistaken for done.
    assign complete = seen_busy && !mem_busywait;
    assign fill     = (state == MEM_READ) && complete;
    assign store    = (state == IDLE) && write && hit;
    assign line     = data[index];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            seen_busy <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                tags[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    seen_busy <= 1'b0;
                    if (write && hit) begin
                        dirty[index] <= 1'b1;
                    end else if (request && !hit) begin
                        state <= (valid[index] && dirty[index]) ? MEM_WRITE : MEM_READ;
                    end
                end
                MEM_WRITE: begin
                    if (complete) begin
                        state     <= MEM_READ;
                        seen_busy <= 1'b0;
                    end else if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end
                end
                MEM_READ: begin
                    if (complete) begin
                        state        <= IDLE;
                        seen_busy    <= 1'b0;
                        tags[index]  <= tag_in;
                        valid[index] <= 1'b1;
                        dirty[index] <= 1'b0;
                    end else if (mem_busywait) begin
                        seen_busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    seen_busy <= 1'b0;
                end
            endcase
        end
    end

    // Data array carries no reset; its contents only matter once the line is valid.
    always_ff @(posedge clock) begin
        if (fill) begin
            data[index] <= mem_readdata;
        end else if (store) begin
            data[index][{offset, 3'b000} +: 8] <= writedata;
        end
    end

    always_comb begin
        readdata      = 8'h00;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'h00;
        mem_writedata = 32'h0;
        if (reset) begin
            case (state)
                IDLE: begin
                    busywait = request && !hit;
                    if (read && !write && hit) begin
                        readdata = line[{offset, 3'b000} +: 8];
                    end
                end
                MEM_WRITE: begin
                    busywait      = 1'b1;
                    mem_write     = 1'b1;
                    mem_address   = {tags[index], index};
                    mem_writedata = line;
                end
                MEM_READ: begin
                    busywait    = 1'b1;
                    mem_read    = 1'b1;
                    mem_address = {tag_in, index};
                end
                default: begin
                    busywait = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed vector bench for dcache_controller
module tb_dcache_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [7:0]  writedata = 8'h00;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        mem_busywait = 1'b0;

    int checks = 0;
    int errors = 0;
    int wr_cycles = 0;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_bw;
    } vec_t;

    vec_t vecs [7];

    dcache_controller dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) if (mem_write) wr_cycles++;

    always @(negedge clock) begin
        #2;
        check("mem_rd_wr_exclusive", {31'd0, mem_read && mem_write}, 32'd0);
    end

    // Called on a negedge once the DUT has entered a memory state; returns on the negedge after completion.
    task automatic serve(input int busy_cycles, input logic [31:0] blk);
        mem_busywait = 1'b1;
        mem_readdata = blk;
        repeat (busy_cycles) @(posedge clock);
        @(negedge clock);
        mem_busywait = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Clean miss: request, check the refill request, serve it, check the served byte.
    task automatic clean_miss(input string name, input logic [7:0] a, input logic [5:0] exp_ma,
                              input logic [31:0] blk, input logic [7:0] exp_rd);
        read = 1'b1; write = 1'b0; address = a;
        #1 check({name, "_bw_miss"}, {31'd0, busywait}, 32'd1);
        @(negedge clock);
        check({name, "_mem_read"}, {31'd0, mem_read}, 32'd1);
        check({name, "_no_mem_write"}, {31'd0, mem_write}, 32'd0);
        check({name, "_mem_addr"}, {26'd0, mem_address}, {26'd0, exp_ma});
        serve(1, blk);
        #1 check({name, "_rdata"}, {24'd0, readdata}, {24'd0, exp_rd});
        check({name, "_bw_done"}, {31'd0, busywait}, 32'd0);
        read = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h27, 8'h00, 8'hDD, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h25, 8'h00, 8'hBB, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h25, 8'h5A, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h5A, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h24, 8'h00, 8'hAA, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h26, 8'h00, 8'hCC, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h25, 8'h00, 8'h00, 1'b0};

        // Reset held with a request pending: every output stays low.
        read = 1'b1; address = 8'h24;
        @(negedge clock);
        #1;
        check("rst_busywait", {31'd0, busywait}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_mem_address", {26'd0, mem_address}, 32'd0);
        check("rst_mem_writedata", mem_writedata, 32'd0);
        check("rst_readdata", {24'd0, readdata}, 32'd0);
        read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Clean miss on 0x24 with 5 busy cycles.
        read = 1'b1; address = 8'h24;
        #1 check("miss1_bw", {31'd0, busywait}, 32'd1);
        @(negedge clock);
        check("miss1_mem_read", {31'd0, mem_read}, 32'd1);
        check("miss1_mem_addr", {26'd0, mem_address}, 32'h09);
        check("miss1_rdata_zero", {24'd0, readdata}, 32'd0);
        mem_busywait = 1'b1;
        mem_readdata = 32'hDDCCBBAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("miss1_hold_mem_read", {31'd0, mem_read}, 32'd1);
            check("miss1_hold_addr", {26'd0, mem_address}, 32'h09);
        end
        mem_busywait = 1'b0;
        @(negedge clock);
        #1;
        check("miss1_rdata", {24'd0, readdata}, 32'hAA);
        check("miss1_bw_done", {31'd0, busywait}, 32'd0);
        check("miss1_mem_read_off", {31'd0, mem_read}, 32'd0);
        check("miss1_no_write", wr_cycles, 32'd0);
        read = 1'b0;
        @(negedge clock);

        // Hit vectors on line 1 (tag 1).
        for (int i = 0; i < 7; i++) begin
            read = vecs[i].rd; write = vecs[i].wr;
            address = vecs[i].addr; writedata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), {24'd0, readdata}, {24'd0, vecs[i].exp_rd});
            check($sformatf("vec%0d_bw", i), {31'd0, busywait}, {31'd0, vecs[i].exp_bw});
            check($sformatf("vec%0d_mem_idle", i), {26'd0, mem_address, mem_read, mem_write}, 32'd0);
            @(negedge clock);
        end
        read = 1'b0; write = 1'b0;
        check("hits_no_write", wr_cycles, 32'd0);

        // Dirty miss on 0x45: write-back then refill.
        read = 1'b1; address = 8'h45;
        #1 check("dirty_bw", {31'd0, busywait}, 32'd1);
        @(negedge clock);
        check("wb_mem_write", {31'd0, mem_write}, 32'd1);
        check("wb_mem_read", {31'd0, mem_read}, 32'd0);
        check("wb_mem_addr", {26'd0, mem_address}, 32'h09);
        check("wb_mem_wdata", mem_writedata, 32'hDDCC5AAA);
        serve(3, 32'h0);
        check("rf_mem_read", {31'd0, mem_read}, 32'd1);
        check("rf_mem_write", {31'd0, mem_write}, 32'd0);
        check("rf_mem_addr", {26'd0, mem_address}, 32'h11);
        check("rf_bw", {31'd0, busywait}, 32'd1);
        check("rf_rdata_zero", {24'd0, readdata}, 32'd0);
        serve(2, 32'h44332211);
        #1 check("dirty_rdata", {24'd0, readdata}, 32'h22);
        check("dirty_bw_done", {31'd0, busywait}, 32'd0);
        read = 1'b0;
        @(negedge clock);

        // Line 1 is clean now: evicting it must not write back.
        clean_miss("clean25", 8'h25, 6'h09, 32'h11223344, 8'h33);
        @(negedge clock);
        clean_miss("clean45", 8'h45, 6'h11, 32'h44332211, 8'h22);
        @(negedge clock);

        // Read and write together on a hit: the write wins.
        read = 1'b1; write = 1'b1; address = 8'h45; writedata = 8'h33;
        #1 check("both_bw", {31'd0, busywait}, 32'd0);
        @(negedge clock);
        write = 1'b0;
        #1 check("both_rdata", {24'd0, readdata}, 32'h33);
        read = 1'b0;
        @(negedge clock);

        // Reset two cycles into a refill busy period.
        read = 1'b1; address = 8'h08;
        @(negedge clock);
        check("rr_mem_read", {31'd0, mem_read}, 32'd1);
        check("rr_mem_addr", {26'd0, mem_address}, 32'h02);
        mem_busywait = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rr_mem_read_drop", {31'd0, mem_read}, 32'd0);
        check("rr_bw_drop", {31'd0, busywait}, 32'd0);
        @(negedge clock);
        read = 1'b0; mem_busywait = 1'b0; reset = 1'b1;
        begin
            logic [7:0] probe [4];
            probe[0] = 8'h08; probe[1] = 8'h45; probe[2] = 8'h24; probe[3] = 8'h00;
            for (int i = 0; i < 4; i++) begin
                read = 1'b1; address = probe[i];
                #1 check($sformatf("rr_invalid_%0d", i), {31'd0, busywait}, 32'd1);
            end
        end
        read = 1'b0;
        @(negedge clock);
        #1 check("rr_idle_after", {30'd0, mem_read, mem_write}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache with its controller, placed between the CPU load/store path and the 32-bit-block data memory. It holds 8 lines of 4 bytes with valid, dirty and 3-bit tag per line. It performs the tag check against the stored tag and sequences dirty-block write-back and block refill over a request/busywait memory handshake. The CPU stalls on `busywait`.

## Interface
- (no parameters) geometry fixed: 8-bit byte address = tag[7:5], index[4:2], offset[1:0]
- `clock` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low
- `read` in 1: CPU load request
- `write` in 1: CPU store request; has priority if `read` is also high
- `address` in 8: CPU byte address
- `writedata` in 8: CPU store data
- `readdata` out 8: load data
- `busywait` out 1: CPU stall
- `mem_read` out 1: block read request
- `mem_write` out 1: block write request
- `mem_address` out 6: block address {tag, index}
- `mem_writedata` out 32: write-back block, byte 0 in [7:0]
- `mem_readdata` in 32: refill block, byte 0 in [7:0]
- `mem_busywait` in 1: memory busy

## Operation
- hit = valid[index] & (tag[index] == address[7:5]).
- Request = `read` | `write`.
- The CPU holds `read`, `write`, `address` and `writedata` stable while `busywait`=1.
- States:
  - IDLE
    - hit read: `readdata` = byte[offset] of line[index], combinational; `busywait`=0.
    - hit write: at the next posedge, byte[offset] ← `writedata` and dirty ← 1; `busywait`=0.
    - miss with line invalid or clean: go to MEM_READ.
    - miss with line valid and dirty: go to MEM_WRITE.
    - `busywait` = request & ~hit.
  - MEM_WRITE: `mem_write`=1, `mem_address`={stored tag, index}, `mem_writedata`=stored block. On completion, go to MEM_READ.
  - MEM_READ: `mem_read`=1, `mem_address`={address[7:5], index}. On completion, at the same posedge: block ← `mem_readdata`, tag ← address[7:5], valid ← 1, dirty ← 0. Then go to IDLE.
- Once back in IDLE, the held request hits and is served as above.
- Memory completion:
  - A 1-bit flag `seen_busy` is set when `mem_busywait` is sampled 1 in MEM_READ or MEM_WRITE.
  - Completion is the first posedge in that state with `mem_busywait`=0 and `seen_busy`=1.
  - `seen_busy` clears on every state change.
- `busywait`=1 throughout MEM_WRITE and MEM_READ.
- `readdata`=8'h00 whenever the block is not in IDLE with a hit read.
- `mem_read`/`mem_write` are never high together and are never high in IDLE.
- In IDLE: `mem_address`=0, `mem_writedata`=0.
- No request in IDLE: no state change, no array update.

## Timing
- Reset (asynchronous, `reset`=0):
  - state ← IDLE; all valid, dirty and tag bits ← 0; `seen_busy` ← 0.
  - `busywait`=0, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0, `readdata`=0 while reset is held.
  - Data array contents are don't-care after reset.
- Reset mid-refill or mid-write-back: the transaction aborts immediately and memory requests drop in the same instant.
- Hit (read or write): 0 stall cycles.
- Clean miss: stall = 1 (enter MEM_READ) + memory cycles through completion + 0. The request is served in the IDLE cycle after the refill edge.
- Dirty miss: stall = MEM_WRITE cycles + MEM_READ cycles; MEM_READ starts the cycle after write-back completion.
- State register, arrays and `seen_busy` update on the rising `clock` only (except reset).
- Memory request outputs are Moore outputs, decoded from state only.

## Test plan
- Reset, then read 0x24 (tag 1, index 1); memory busy 5 cycles returning 0xDDCCBBAA:
  - `mem_read`=1 with `mem_address`=0x09 until completion.
  - Then `readdata`=0xAA and `busywait`=0 in the next cycle.
  - No `mem_write` occurs.
- After the fill above, read 0x27:
  - `readdata`=0xDD with 0 stall cycles and no memory activity.
- Write 0x5A to 0x25, then read 0x25:
  - 0 stalls; `readdata`=0x5A; line 1 becomes dirty.
- Then read 0x45 (tag 2, index 1):
  - MEM_WRITE first: `mem_address`=0x09, `mem_writedata`=0xDDCC5AAA.
  - Then MEM_READ with `mem_address`=0x11.
  - Final `readdata` = byte 1 of the new block; line 1 is clean.
- `read` and `write` both high on a hit to 0x45 with `writedata`=0x33:
  - Treated as a write; a subsequent read returns 0x33.
- Assert `reset` low during MEM_READ, 2 cycles into the memory busy period:
  - `mem_read` and `busywait` drop asynchronously.
  - After release, a read to the same address misses again; all lines are invalid.
